// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU memory subsystem: RAM handshake states,
// bus-arbiter FSM encoding and the machine word width.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Wrapped priority search: first active requester at or after rr_ptr_i,
// wrapping modulo NREQ. Purely combinational.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_act_i,
   input  logic [IDXW-1:0] rr_ptr_i,
   output logic            valid_o,
   output logic [IDXW-1:0] idx_o
);

   logic [31:0]     sum;
   logic [IDXW-1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      sum     = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         // rr_ptr_i < NREQ and k < NREQ, so one subtraction wraps the sum
         sum = 32'(rr_ptr_i) + k;
         if (sum >= 32'(NREQ)) begin
            sum = sum - 32'(NREQ);
         end
         cand = sum[IDXW-1:0];
         if (!valid_o && req_act_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the single RAM port among NREQ cache requesters,
// holding each grant until ACCESS, with a sticky per-transaction watchdog.
module mem_bus_arbiter
   import cpu_types_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int TIMEOUT = 64,
   localparam int IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic [NREQ-1:0]             req_ren,
   input  logic [NREQ-1:0]             req_wen,
   input  logic [NREQ-1:0][WORD_W-1:0] req_addr,
   input  logic [NREQ-1:0][WORD_W-1:0] req_store,
   output logic [NREQ-1:0]             req_wait,
   output logic [WORD_W-1:0]           req_load,
   output logic                        ramREN,
   output logic                        ramWEN,
   output logic [WORD_W-1:0]           ramaddr,
   output logic [WORD_W-1:0]           ramstore,
   input  logic [WORD_W-1:0]           ramload,
   input  ramstate_t                   ramstate,
   output logic [IDXW-1:0]             grant_idx,
   output logic                        error_flag
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   arb_state_t      state_q;
   logic [IDXW-1:0] grant_q;
   logic [IDXW-1:0] rr_ptr_q;
   logic [IDXW-1:0] rr_ptr_d;
   logic [WDW-1:0]  wd_q;
   logic            err_q;

   logic [NREQ-1:0] req_act;
   logic            pick_valid;
   logic [IDXW-1:0] pick_idx;

   assign req_act = req_ren | req_wen;

   rr_picker #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_picker (
      .req_act_i (req_act),
      .rr_ptr_i  (rr_ptr_q),
      .valid_o   (pick_valid),
      .idx_o     (pick_idx)
   );

   assign rr_ptr_d = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_q <= pick_idx;
                  wd_q    <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if ((ramstate != ACCESS) && (wd_q == WDW'(TIMEOUT - 1))) begin
                  err_q <= 1'b1;
               end
               // An abort leaves rr_ptr alone so the aborting requester keeps priority
               if (!req_act[grant_q]) begin
                  state_q <= IDLE;
               end else if (ramstate == ACCESS) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= rr_ptr_d;
               end else if (wd_q != WDW'(TIMEOUT)) begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      req_load = '0;
      req_wait = req_act;
      if (state_q == GRANT) begin
         ramaddr  = req_addr[grant_q];
         ramstore = req_store[grant_q];
         ramWEN   = req_wen[grant_q];
         ramREN   = req_ren[grant_q] & ~req_wen[grant_q];
         req_load = ramload;
         if (ramstate == ACCESS) begin
            req_wait[grant_q] = 1'b0;
         end
      end
   end

   assign grant_idx  = grant_q;
   assign error_flag = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected completions are queued when
// a request is driven and checked in the ACCESS cycle.
module tb_mem_bus_arbiter;
   import cpu_types_pkg::*;

   localparam int NREQ = 4;
   localparam int TMO  = 8;
   localparam int IDXW = 2;

   logic                  CLK = 1'b0;
   logic                  nRST = 1'b1;
   logic [NREQ-1:0]       req_ren, req_wen, req_wait;
   logic [NREQ-1:0][31:0] req_addr, req_store;
   logic [31:0]           req_load, ramaddr, ramstore, ramload;
   logic                  ramREN, ramWEN, error_flag;
   ramstate_t             ramstate;
   logic [IDXW-1:0]       grant_idx;

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 CLK = ~CLK;

   mem_bus_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TMO)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .req_ren    (req_ren),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_store  (req_store),
      .req_wait   (req_wait),
      .req_load   (req_load),
      .ramREN     (ramREN),
      .ramWEN     (ramWEN),
      .ramaddr    (ramaddr),
      .ramstore   (ramstore),
      .ramload    (ramload),
      .ramstate   (ramstate),
      .grant_idx  (grant_idx),
      .error_flag (error_flag)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      req_ren   = '0;
      req_wen   = '0;
      req_addr  = '0;
      req_store = '0;
      ramload   = '0;
      ramstate  = FREE;
   endtask

   task automatic do_reset();
      clear_inputs();
      nRST = 1'b0;
      @(negedge CLK);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      ramload  = 32'hA5A5_A5A5;
      ramstate = ACCESS;
      req_ren  = 4'b0101;
      req_wen  = 4'b1000;
      req_addr[0] = 32'h44;
      #3 nRST = 1'b0;
      #1;
      n_checks++; if (req_wait !== 4'b1101) begin n_fail++; $display("FAIL rst_req_wait: got %b expected 1101", req_wait); end
      n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL rst_enables: got %b expected 00", {ramREN, ramWEN}); end
      n_checks++; if ({ramaddr, ramstore} !== 64'h0) begin n_fail++; $display("FAIL rst_addr_store: got %h expected 0", {ramaddr, ramstore}); end
      n_checks++; if (req_load !== 32'h0) begin n_fail++; $display("FAIL rst_req_load: got %h expected 0", req_load); end
      n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rst_grant_idx: got %0d expected 0", grant_idx); end
      n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL rst_error_flag: got %b expected 0", error_flag); end
      @(negedge CLK);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      clear_inputs();
   endtask

   task automatic test_single_read();
      exp_t e;
      do_reset();
      req_ren[1]  = 1'b1;
      req_addr[1] = 32'h40;
      e.idx = 2'd1; e.addr = 32'h40; e.wr = 1'b0; e.data = 32'hDEADBEEF;
      sb.push_back(e);
      @(negedge CLK);
      n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL sr_req_cycle_ren: got %b expected 0", ramREN); end
      n_checks++; if (req_wait !== 4'b0010) begin n_fail++; $display("FAIL sr_req_cycle_wait: got %b expected 0010", req_wait); end
      step();
      ramstate = BUSY;
      @(negedge CLK);
      n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL sr_ren_latency: got %b expected 1", ramREN); end
      n_checks++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL sr_ramaddr: got %h expected 00000040", ramaddr); end
      step();
      @(negedge CLK);
      n_checks++; if (req_wait !== 4'b0010) begin n_fail++; $display("FAIL sr_busy_wait: got %b expected 0010", req_wait); end
      step();
      ramstate = ACCESS;
      ramload  = 32'hDEADBEEF;
      @(negedge CLK);
      e = sb.pop_front();
      n_checks++; if (grant_idx !== e.idx) begin n_fail++; $display("FAIL sr_grant: got %0d expected %0d", grant_idx, e.idx); end
      n_checks++; if (ramWEN !== e.wr) begin n_fail++; $display("FAIL sr_wen: got %b expected %b", ramWEN, e.wr); end
      n_checks++; if (req_wait !== 4'b0000) begin n_fail++; $display("FAIL sr_access_wait: got %b expected 0000", req_wait); end
      n_checks++; if (req_load !== e.data) begin n_fail++; $display("FAIL sr_req_load: got %h expected %h", req_load, e.data); end
      step();
      req_ren = 4'b0101;
      req_addr[0] = 32'h10;
      req_addr[2] = 32'h20;
      ramstate = FREE;
      ramload  = '0;
      @(negedge CLK);
      n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL sr_idle_gap: got %b expected 0", ramREN); end
      n_checks++; if (req_load !== 32'h0) begin n_fail++; $display("FAIL sr_idle_load: got %h expected 0", req_load); end
      step();
      @(negedge CLK);
      n_checks++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL sr_rr_ptr_after: got %0d expected 2", grant_idx); end
      n_checks++; if (ramaddr !== 32'h20) begin n_fail++; $display("FAIL sr_rr_addr_after: got %h expected 00000020", ramaddr); end
      clear_inputs();
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sr_sb_empty: got %0d expected 0", sb.size()); end
   endtask

   task automatic test_round_robin();
      exp_t       e;
      logic [3:0] exp_wait;
      do_reset();
      req_ren  = '1;
      ramstate = ACCESS;
      ramload  = 32'h1000_0000;
      for (int i = 0; i < NREQ; i++) req_addr[i] = 32'h100 + 32'(4 * i);
      for (int k = 0; k < 5; k++) begin
         e.idx = 2'(k % NREQ); e.addr = 32'h100 + 32'(4 * (k % NREQ)); e.wr = 1'b0; e.data = 32'h1000_0000;
         sb.push_back(e);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         if (c % 2 == 1) begin
            e = sb.pop_front();
            exp_wait = 4'b1111 & ~(4'b0001 << e.idx);
            n_checks++; if (grant_idx !== e.idx) begin n_fail++; $display("FAIL rr_order c%0d: got %0d expected %0d", c, grant_idx, e.idx); end
            n_checks++; if (ramaddr !== e.addr) begin n_fail++; $display("FAIL rr_addr c%0d: got %h expected %h", c, ramaddr, e.addr); end
            n_checks++; if (req_wait !== exp_wait) begin n_fail++; $display("FAIL rr_wait c%0d: got %b expected %b", c, req_wait, exp_wait); end
         end else begin
            n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL rr_idle c%0d: got %b expected 0", c, ramREN); end
         end
         step();
      end
      clear_inputs();
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rr_sb_empty: got %0d expected 0", sb.size()); end
   endtask

   task automatic test_rw_both();
      exp_t e;
      do_reset();
      req_ren[2]   = 1'b1;
      req_wen[2]   = 1'b1;
      req_addr[2]  = 32'h80;
      req_store[2] = 32'h1234;
      ramstate     = BUSY;
      e.idx = 2'd2; e.addr = 32'h80; e.wr = 1'b1; e.data = 32'h1234;
      sb.push_back(e);
      @(negedge CLK);
      n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL rw_idle_wen: got %b expected 0", ramWEN); end
      step();
      @(negedge CLK);
      n_checks++; if ({ramWEN, ramREN} !== 2'b10) begin n_fail++; $display("FAIL rw_enables: got %b expected 10", {ramWEN, ramREN}); end
      n_checks++; if (ramstore !== 32'h1234) begin n_fail++; $display("FAIL rw_store: got %h expected 00001234", ramstore); end
      step();
      ramstate = ACCESS;
      @(negedge CLK);
      e = sb.pop_front();
      n_checks++; if (grant_idx !== e.idx) begin n_fail++; $display("FAIL rw_grant: got %0d expected %0d", grant_idx, e.idx); end
      n_checks++; if (ramaddr !== e.addr) begin n_fail++; $display("FAIL rw_addr: got %h expected %h", ramaddr, e.addr); end
      n_checks++; if (ramstore !== e.data) begin n_fail++; $display("FAIL rw_access_store: got %h expected %h", ramstore, e.data); end
      n_checks++; if (req_wait !== 4'b0000) begin n_fail++; $display("FAIL rw_access_wait: got %b expected 0000", req_wait); end
      step();
      clear_inputs();
   endtask

   task automatic test_abort();
      exp_t e;
      do_reset();
      req_ren[2]  = 1'b1;
      req_addr[2] = 32'h20;
      ramstate    = ACCESS;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL ab_pre_grant: got %0d expected 2", grant_idx); end
      step();
      req_ren[2]   = 1'b0;
      req_wen[3]   = 1'b1;
      req_addr[3]  = 32'hC0;
      req_store[3] = 32'h55;
      ramstate     = BUSY;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if (grant_idx !== 2'd3) begin n_fail++; $display("FAIL ab_grant3: got %0d expected 3", grant_idx); end
      n_checks++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL ab_busy1_wen: got %b expected 1", ramWEN); end
      step();
      @(negedge CLK);
      n_checks++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL ab_busy2_wen: got %b expected 1", ramWEN); end
      step();
      req_wen[3]  = 1'b0;
      req_ren[0]  = 1'b1;
      req_addr[0] = 32'h04;
      @(negedge CLK);
      n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL ab_drop_enables: got %b expected 00", {ramREN, ramWEN}); end
      n_checks++; if (req_wait !== 4'b0001) begin n_fail++; $display("FAIL ab_drop_wait: got %b expected 0001", req_wait); end
      step();
      req_wen[3] = 1'b1;
      e.idx = 2'd3; e.addr = 32'hC0; e.wr = 1'b1; e.data = 32'h55;
      sb.push_back(e);
      @(negedge CLK);
      n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL ab_back_idle: got %b expected 00", {ramREN, ramWEN}); end
      step();
      ramstate = ACCESS;
      @(negedge CLK);
      e = sb.pop_front();
      n_checks++; if (grant_idx !== e.idx) begin n_fail++; $display("FAIL ab_regrant: got %0d expected %0d", grant_idx, e.idx); end
      n_checks++; if (ramaddr !== e.addr) begin n_fail++; $display("FAIL ab_regrant_addr: got %h expected %h", ramaddr, e.addr); end
      n_checks++; if (ramstore !== e.data) begin n_fail++; $display("FAIL ab_regrant_store: got %h expected %h", ramstore, e.data); end
      n_checks++; if (req_wait !== 4'b0001) begin n_fail++; $display("FAIL ab_regrant_wait: got %b expected 0001", req_wait); end
      step();
      req_wen[3] = 1'b0;
      ramstate   = BUSY;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL ab_next_grant: got %0d expected 0", grant_idx); end
      n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL ab_next_ren: got %b expected 1", ramREN); end
      step();
      clear_inputs();
   endtask

   task automatic test_watchdog();
      exp_t e;
      do_reset();
      req_ren[1]  = 1'b1;
      req_addr[1] = 32'h60;
      ramstate    = BUSY;
      e.idx = 2'd1; e.addr = 32'h60; e.wr = 1'b0; e.data = 32'hCAFEF00D;
      sb.push_back(e);
      @(negedge CLK);
      step();
      for (int k = 1; k <= TMO; k++) begin
         @(negedge CLK);
         n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL wd_early grant_cycle%0d: got %b expected 0", k, error_flag); end
         step();
      end
      @(negedge CLK);
      n_checks++; if (error_flag !== 1'b1) begin n_fail++; $display("FAIL wd_set: got %b expected 1", error_flag); end
      n_checks++; if ({ramREN, req_wait} !== 5'b1_0010) begin n_fail++; $display("FAIL wd_still_waiting: got %b expected 10010", {ramREN, req_wait}); end
      step();
      ramstate = ACCESS;
      ramload  = 32'hCAFEF00D;
      @(negedge CLK);
      e = sb.pop_front();
      n_checks++; if (grant_idx !== e.idx) begin n_fail++; $display("FAIL wd_grant: got %0d expected %0d", grant_idx, e.idx); end
      n_checks++; if (req_load !== e.data) begin n_fail++; $display("FAIL wd_load: got %h expected %h", req_load, e.data); end
      n_checks++; if (req_wait !== 4'b0000) begin n_fail++; $display("FAIL wd_access_wait: got %b expected 0000", req_wait); end
      step();
      clear_inputs();
      @(negedge CLK);
      n_checks++; if (error_flag !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b expected 1", error_flag); end
      step();
   endtask

   task automatic test_reset_mid_grant();
      clear_inputs();
      req_ren[3]  = 1'b1;
      req_addr[3] = 32'h3C;
      ramstate    = BUSY;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if ({ramREN, grant_idx} !== 3'b1_11) begin n_fail++; $display("FAIL mr_pre_grant: got %b expected 111", {ramREN, grant_idx}); end
      #2 nRST = 1'b0;
      #1;
      n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL mr_async_enables: got %b expected 00", {ramREN, ramWEN}); end
      n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL mr_error_clr: got %b expected 0", error_flag); end
      n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL mr_grant_clr: got %0d expected 0", grant_idx); end
      n_checks++; if (req_wait !== 4'b1000) begin n_fail++; $display("FAIL mr_wait: got %b expected 1000", req_wait); end
      step();
      nRST    = 1'b1;
      req_ren = 4'b1010;
      req_addr[1] = 32'h14;
      @(negedge CLK);
      n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL mr_idle_after: got %b expected 0", ramREN); end
      step();
      @(negedge CLK);
      n_checks++; if (grant_idx !== 2'd1) begin n_fail++; $display("FAIL mr_restart_ptr: got %0d expected 1", grant_idx); end
      n_checks++; if (ramaddr !== 32'h14) begin n_fail++; $display("FAIL mr_restart_addr: got %h expected 00000014", ramaddr); end
      step();
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_rw_both();
      test_abort();
      test_watchdog();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
